// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-serial DRAM instruction writer; optional terminator via PROGRAM_LOADER_AUTO_TERM_EN
module program_loader #(
    parameter int                    ADDR_WIDTH  = 24,
    parameter int                    INSTR_WIDTH = 64,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    MAX_INSTRS  = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INSTR_WIDTH-1:0]             in_instr,
    input  logic                               in_last,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(MAX_INSTRS+1)-1:0]    count,
    output logic                               err
);

    localparam int CW    = $clog2(MAX_INSTRS + 1);
    localparam int BYTES = INSTR_WIDTH / DATA_WIDTH;
`ifdef PROGRAM_LOADER_AUTO_TERM_EN
    // One slot is reserved for the all-zero terminator.
    localparam int CAPACITY = MAX_INSTRS - 1;
`else
    localparam int CAPACITY = MAX_INSTRS;
`endif
    localparam logic [CW-1:0] CAP_C     = CW'(CAPACITY);
    localparam logic [2:0]    LAST_BYTE = 3'(BYTES - 1);

    typedef enum logic [2:0] {
        L_IDLE,
        L_ACCEPT,
        L_WRITE,
        L_TERM,
        L_DONE
    } state_t;

    state_t                  state_q, state_d;
    // count doubles as the current slot index: both reset together and advance together.
    logic [CW-1:0]           count_q, count_d;
    logic                    err_q, err_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic                    last_q, last_d;
    logic [2:0]              byte_q, byte_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    // Byte address of byte 0 of a slot; wraps silently modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [CW-1:0] slot);
        return BASE_ADDR + ADDR_WIDTH'({slot, 3'b000});
    endfunction

    // Next-state and next-output decode; the write port is loaded one cycle ahead so mem_* leave flops.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        instr_d     = instr_q;
        last_d      = last_q;
        byte_d      = byte_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            L_IDLE: begin
                if (start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = L_ACCEPT;
                end
            end
            L_ACCEPT: begin
                if (in_valid) begin
                    // Low byte goes out immediately; the rest shift down one byte per write.
                    instr_d = in_instr >> DATA_WIDTH;
                    last_d  = in_last;
                    byte_d  = '0;
                    if (count_q < CAP_C) begin
                        state_d     = L_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = slot_addr(count_q);
                        mem_wdata_d = in_instr[DATA_WIDTH-1:0];
                    end else begin
                        err_d = 1'b1;
                        if (in_last) begin
`ifdef PROGRAM_LOADER_AUTO_TERM_EN
                            state_d     = L_TERM;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = slot_addr(count_q);
                            mem_wdata_d = '0;
`else
                            state_d     = L_DONE;
`endif
                        end
                    end
                end
            end
            L_WRITE: begin
                if (byte_q != LAST_BYTE) begin
                    byte_d      = byte_q + 3'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
                    mem_wdata_d = instr_q[DATA_WIDTH-1:0];
                    instr_d     = instr_q >> DATA_WIDTH;
                end else begin
                    count_d = count_q + CW'(1);
                    if (last_q) begin
`ifdef PROGRAM_LOADER_AUTO_TERM_EN
                        state_d     = L_TERM;
                        byte_d      = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = slot_addr(count_q + CW'(1));
                        mem_wdata_d = '0;
`else
                        state_d     = L_DONE;
`endif
                    end else begin
                        state_d = L_ACCEPT;
                    end
                end
            end
`ifdef PROGRAM_LOADER_AUTO_TERM_EN
            L_TERM: begin
                if (byte_q != LAST_BYTE) begin
                    byte_d      = byte_q + 3'd1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
                    mem_wdata_d = '0;
                end else begin
                    state_d = L_DONE;
                end
            end
`endif
            L_DONE: begin
                state_d = L_IDLE;
            end
            default: begin
                state_d = L_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= L_IDLE;
            count_q     <= '0;
            err_q       <= 1'b0;
            instr_q     <= '0;
            last_q      <= 1'b0;
            byte_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            instr_q     <= instr_d;
            last_q      <= last_d;
            byte_q      <= byte_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = (state_q == L_ACCEPT);
    assign busy      = (state_q != L_IDLE);
    assign done      = (state_q == L_DONE);
    assign count     = count_q;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    localparam int          AW   = 24;
    localparam int          IW   = 64;
    localparam int          DW   = 8;
    localparam int          MAXI = 4;
    localparam logic [23:0] BASE = 24'hFFFFF0;
    localparam int          CW   = $clog2(MAXI + 1);
`ifdef PROGRAM_LOADER_AUTO_TERM_EN
    localparam int TERM_EN = 1;
`else
    localparam int TERM_EN = 0;
`endif
    localparam int CAP = MAXI - TERM_EN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_instr = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int            wc[$];
    int            acc[$];
    int            dn[$];
    logic [IW-1:0] beats[0:7];

    program_loader #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (BASE),
        .MAX_INSTRS (MAXI)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_last  (in_last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (in_valid && in_ready) acc.push_back(cyc);
        if (done) dn.push_back(cyc);
    end

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        wc.delete();
        acc.delete();
        dn.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_seq(input int n);
        int i;
        int guard;
        i = 0;
        guard = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = beats[0];
        in_last  = (n == 1);
        while (i < n && guard < 500) begin
            @(negedge clk);
            if (in_ready) begin
                i++;
                @(posedge clk); #1;
                if (i < n) begin
                    in_instr = beats[i];
                    in_last  = (i == n - 1);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
            guard++;
        end
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL send_timeout accepted=%0d required=%0d", i, n);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (dn.size() == 0 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++;
        if (dn.size() == 0) begin
            failures++;
            $display("FAIL done_timeout got=none required=pulse");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (mem_we !== 1'b0)    begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0)       begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (count !== '0)       begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (mem_addr !== '0)    begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0)   begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    endtask

    task automatic test_single();
        int            exp_n;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [IW-1:0] b;
        clear_logs();
        beats[0] = 64'h0123456789ABCDEF;
        pulse_start();
        send_seq(1);
        wait_done();
        exp_n = 8 + 8 * TERM_EN;
        checks++; if (acc.size() != 1)     begin failures++; $display("FAIL single_accepts got=%0d exp=1", acc.size()); end
        checks++; if (wa.size() != exp_n)  begin failures++; $display("FAIL single_nwrites got=%0d exp=%0d", wa.size(), exp_n); end
        for (int i = 0; i < exp_n && i < wa.size() && acc.size() > 0; i++) begin
            ea = BASE + 24'(i);
            b  = beats[0];
            ed = (i < 8) ? b[8*i +: 8] : 8'h00;
            checks++; if (wa[i] !== ea) begin failures++; $display("FAIL single_addr[%0d] got=%h exp=%h", i, wa[i], ea); end
            checks++; if (wd[i] !== ed) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", i, wd[i], ed); end
            checks++; if (wc[i] != acc[0] + 1 + i) begin failures++; $display("FAIL single_wcyc[%0d] got=%0d exp=%0d", i, wc[i], acc[0] + 1 + i); end
        end
        if (acc.size() > 0 && dn.size() > 0) begin
            checks++;
            if (dn[0] != acc[0] + 9 + 8 * TERM_EN) begin
                failures++;
                $display("FAIL single_done_cyc got=%0d exp=%0d", dn[0], acc[0] + 9 + 8 * TERM_EN);
            end
        end
        checks++; if (count !== CW'(1)) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (err !== 1'b0)     begin failures++; $display("FAIL single_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int            exp_n;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [IW-1:0] b;
        clear_logs();
        beats[0] = 64'h1111111111111111;
        beats[1] = 64'hA5A5A5A55A5A5A5A;
        beats[2] = 64'h8877665544332211;
        pulse_start();
        send_seq(3);
        wait_done();
        exp_n = 24 + 8 * TERM_EN;
        checks++; if (acc.size() != 3)    begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size()); end
        if (acc.size() == 3) begin
            checks++; if (acc[1] - acc[0] != 9) begin failures++; $display("FAIL b2b_gap01 got=%0d exp=9", acc[1] - acc[0]); end
            checks++; if (acc[2] - acc[1] != 9) begin failures++; $display("FAIL b2b_gap12 got=%0d exp=9", acc[2] - acc[1]); end
        end
        checks++; if (wa.size() != exp_n) begin failures++; $display("FAIL b2b_nwrites got=%0d exp=%0d", wa.size(), exp_n); end
        for (int i = 0; i < exp_n && i < wa.size(); i++) begin
            ea = BASE + 24'(i);
            b  = beats[(i < 24) ? i / 8 : 0];
            ed = (i < 24) ? b[8*(i%8) +: 8] : 8'h00;
            checks++; if (wa[i] !== ea) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, wa[i], ea); end
            checks++; if (wd[i] !== ed) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, wd[i], ed); end
        end
        if (wa.size() > 16) begin
            checks++; if (wa[16] !== 24'h000000) begin failures++; $display("FAIL b2b_wrap_addr got=%h exp=000000", wa[16]); end
        end
        checks++; if (count !== CW'(3)) begin failures++; $display("FAIL b2b_count got=%0d exp=3", count); end
    endtask

    task automatic test_overflow();
        int            exp_n;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [IW-1:0] b;
        clear_logs();
        for (int i = 0; i < 5; i++) beats[i] = {8{8'(8'h10 * (i + 1) + i)}};
        pulse_start();
        send_seq(5);
        wait_done();
        exp_n = 8 * CAP + 8 * TERM_EN;
        checks++; if (acc.size() != 5)    begin failures++; $display("FAIL ovf_accepts got=%0d exp=5", acc.size()); end
        checks++; if (wa.size() != exp_n) begin failures++; $display("FAIL ovf_nwrites got=%0d exp=%0d", wa.size(), exp_n); end
        for (int i = 0; i < exp_n && i < wa.size(); i++) begin
            ea = BASE + 24'(i);
            b  = beats[(i < 8 * CAP) ? i / 8 : 0];
            ed = (i < 8 * CAP) ? b[8*(i%8) +: 8] : 8'h00;
            checks++; if (wa[i] !== ea) begin failures++; $display("FAIL ovf_addr[%0d] got=%h exp=%h", i, wa[i], ea); end
            checks++; if (wd[i] !== ed) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, wd[i], ed); end
        end
        checks++; if (err !== 1'b1)       begin failures++; $display("FAIL ovf_err got=%b exp=1", err); end
        checks++; if (count !== CW'(CAP)) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", count, CAP); end
        pulse_start();
        @(negedge clk);
        checks++; if (err !== 1'b0)   begin failures++; $display("FAIL ovf_err_clear got=%b exp=0", err); end
        checks++; if (busy !== 1'b1)  begin failures++; $display("FAIL ovf_restart_busy got=%b exp=1", busy); end
        checks++; if (count !== '0)   begin failures++; $display("FAIL ovf_restart_count got=%0d exp=0", count); end
        clear_logs();
        beats[0] = 64'h0000000000000000;
        send_seq(1);
        wait_done();
        checks++; if (count !== CW'(1)) begin failures++; $display("FAIL ovf_zero_instr_count got=%0d exp=1", count); end
    endtask

    task automatic test_reset_mid();
        int guard;
        clear_logs();
        beats[0] = 64'hDEADBEEFCAFEF00D;
        pulse_start();
        send_seq(1);
        guard = 0;
        while (wa.size() < 4 && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++; if (wa.size() != 4) begin failures++; $display("FAIL mid_reach_byte4 got=%0d exp=4", wa.size()); end
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0)   begin failures++; $display("FAIL mid_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== '0)   begin failures++; $display("FAIL mid_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0)  begin failures++; $display("FAIL mid_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL mid_done got=%b exp=0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        beats[0] = 64'h0807060504030201;
        pulse_start();
        send_seq(1);
        wait_done();
        checks++; if (wa.size() < 1 || wa[0] !== BASE) begin failures++; $display("FAIL mid_restart_slot0 got=%h exp=%h", (wa.size() > 0) ? wa[0] : 24'hxxxxxx, BASE); end
        checks++; if (wd.size() < 1 || wd[0] !== 8'h01) begin failures++; $display("FAIL mid_restart_byte0 got=%h exp=01", (wd.size() > 0) ? wd[0] : 8'hxx); end
        checks++; if (count !== CW'(1)) begin failures++; $display("FAIL mid_restart_count got=%0d exp=1", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
